apb_multi_master: RTL and testbench
===================================

APB_MULTI_MASTER -- requirements
Module: apb_multi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter NUM_SLV, default 4, slave count; power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum ACCESS wait cycles (used only with APB_TIMEOUT_EN).
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-high.
- pclk  in  1  clock; all state on rising edge
- preset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  master can accept a command
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  DATA_W  read data
- rsp_err_o  out  1  slave error or timeout
- paddr_o  out  ADDR_W  APB PADDR
- pwrite_o  out  1  APB PWRITE
- pwdata_o  out  DATA_W  APB PWDATA
- psel_o  out  NUM_SLV  one-hot APB PSEL
- penable_o  out  1  APB PENABLE
- prdata_i  in  NUM_SLV*DATA_W  per-slave PRDATA, slave k at bits [k*DATA_W +: DATA_W]
- pready_i  in  NUM_SLV  per-slave PREADY
- pslverr_i  in  NUM_SLV  per-slave PSLVERR

Function
REQ-006 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-007 IDLE SHALL assert cmd_ready_o=1; all psel_o bits and penable_o SHALL be 0.
REQ-008 In IDLE, cmd_valid_i=1 SHALL capture write, addr and wdata into registers, then go to SETUP; cmd_ready_o SHALL be 0 outside IDLE.
REQ-009 Slave index SHALL be the top log2(NUM_SLV) bits of the captured address; paddr_o SHALL carry the full captured address.
REQ-010 SETUP SHALL last exactly one cycle: psel_o one-hot at the slave index, penable_o=0, then go to ACCESS.
REQ-011 ACCESS SHALL hold psel_o, set penable_o=1, and keep paddr_o/pwrite_o/pwdata_o stable until completion.
REQ-012 ACCESS SHALL sample only the selected slave's pready_i, pslverr_i and prdata_i; other slaves' inputs SHALL be ignored.
REQ-013 On selected pready_i=1 in ACCESS: next cycle rsp_valid_o=1 for one cycle, rsp_err_o=pslverr_i, rsp_rdata_o=prdata_i (reads) or 0 (writes); FSM SHALL go to IDLE.
REQ-014 Zero-wait latency: accept at edge N, SETUP N+1, ACCESS N+2, rsp_valid_o high in cycle N+3 with cmd_ready_o=1 in the same cycle.
REQ-015 Each low pready_i cycle in ACCESS SHALL add exactly one cycle of latency.
REQ-016 rsp_rdata_o and rsp_err_o SHALL hold their values until the next response.
REQ-017 cmd_valid_i outside IDLE SHALL be ignored; commands are not queued.

Reset
REQ-018 preset=1 SHALL immediately force IDLE, cmd_ready_o=0 while asserted, and rsp_valid_o, rsp_rdata_o, rsp_err_o, paddr_o, pwrite_o, pwdata_o, psel_o and penable_o to 0.
REQ-019 Reset mid-transaction SHALL discard the transaction with no response; first command accepted on the first edge after deassertion.

Configuration
REQ-020 With macro APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with pready_i low; at TIMEOUT cycles it SHALL abort: psel_o/penable_o to 0, rsp_valid_o pulse with rsp_err_o=1, rsp_rdata_o=0, then IDLE.
REQ-021 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for pready_i and no counter SHALL be synthesized.

Verification
REQ-022 Write addr 0x40, data 0x1234ABCD, slave 1 pready always 1 -> psel_o=0010, penable_o high one cycle, rsp_valid_o at N+3, rsp_err_o=0.
REQ-023 Read addr 0xC4, slave 3 prdata 0x5678EF01, 2 wait cycles -> rsp_valid_o at N+5, rsp_rdata_o=0x5678EF01; slaves 0-2 inputs ignored.
REQ-024 Read addr 0x00 with slave 0 pslverr_i=1 at pready -> rsp_err_o=1, FSM returns to IDLE.
REQ-025 Assert preset during ACCESS of write to 0x80 -> all outputs 0 that cycle, no rsp_valid_o; next write completes normally.
REQ-026 APB_TIMEOUT_EN, TIMEOUT=15, slave 2 pready_i stuck 0 -> abort after 15 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0; without macro psel_o stays asserted for 100 cycles.
REQ-027 cmd_valid_i held high through two back-to-back writes -> second accepted only in the rsp_valid_o cycle of the first; no overlap of psel_o.

Source files
------------

// File: rtl/apb_multi_master.sv
// APB requester that talks to NUM_SLV slaves. The slave is picked by the
// top address bits, and each command runs through IDLE -> SETUP -> ACCESS.
// An optional ACCESS timeout is compiled in with `define APB_TIMEOUT_EN;
// without that macro, ACCESS waits for PREADY indefinitely.
module apb_multi_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDR_W-1:0]         cmd_addr_i,
    input  logic [DATA_W-1:0]         cmd_wdata_i,
    output logic                      rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    output logic [NUM_SLV-1:0]        psel_o,
    output logic                      penable_o,
    input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]        pready_i,
    input  logic [NUM_SLV-1:0]        pslverr_i
);
    localparam int SW = $clog2(NUM_SLV);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic [SW-1:0]       slv_idx;
    logic [DATA_W-1:0]   rdata_arr [NUM_SLV];
    logic                sel_ready, sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                take, done, abort;

    // Unpack the flat PRDATA bus so the selected slave can be indexed directly.
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_unpack
        assign rdata_arr[k] = prdata_i[k*DATA_W +: DATA_W];
    end

    // Only the addressed slave's handshake is looked at; the others are don't-care.
    assign slv_idx   = addr_q[ADDR_W-1 -: SW];
    assign sel_ready = pready_i[slv_idx];
    assign sel_err   = pslverr_i[slv_idx];
    assign sel_rdata = rdata_arr[slv_idx];

    assign take = (state_q == IDLE) && cmd_valid_i;
    assign done = (state_q == ACCESS) && sel_ready;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Reaching the last allowed stalled cycle aborts the transfer.
    assign abort = (state_q == ACCESS) && !sel_ready && (tmo_q == TW'(TIMEOUT - 1));

    // Count stalled ACCESS cycles; cleared whenever we are not stalling.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            tmo_q <= '0;
        else if ((state_q == ACCESS) && !sel_ready)
            tmo_q <= tmo_q + 1'b1;
        else
            tmo_q <= '0;
    end
`else
    assign abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: SETUP is always a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs, which are decoded from the state and the captured command.
    always_comb begin
        cmd_ready_o = (state_q == IDLE) && !preset;
        psel_o      = '0;
        penable_o   = 1'b0;
        if (state_q != IDLE)   psel_o    = NUM_SLV'(1) << slv_idx;
        if (state_q == ACCESS) penable_o = 1'b1;
    end

    // Command capture, plus a response register that holds its value until the next completion.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (take) begin
                write_q <= cmd_write_i;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
            end
            rsp_valid_q <= done || abort;
            if (done) begin
                rsp_err_q   <= sel_err;
                rsp_rdata_q <= write_q ? '0 : sel_rdata;
            end else if (abort) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign paddr_o     = addr_q;
    assign pwrite_o    = write_q;
    assign pwdata_o    = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_multi_master.sv
// Scoreboard bench for apb_multi_master. The driver issues commands and
// plays every slave at random. It pushes each expected response (its
// cycle, error flag and read data) into a queue. A monitor pops that
// queue on every rsp_valid_o.
module tb_apb_multi_master;
    localparam int AW = 8, DW = 32, NS = 4, TMO = 15;

    logic               pclk = 1'b0, preset = 1'b1;
    logic               cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic               cmd_ready_o;
    logic [AW-1:0]      cmd_addr_i = '0;
    logic [DW-1:0]      cmd_wdata_i = '0;
    logic               rsp_valid_o, rsp_err_o, pwrite_o, penable_o;
    logic [DW-1:0]      rsp_rdata_o, pwdata_o;
    logic [AW-1:0]      paddr_o;
    logic [NS-1:0]      psel_o, pready_i = '0, pslverr_i = '0;
    logic [NS*DW-1:0]   prdata_i = '0;

    apb_multi_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; bit wr; logic [DW-1:0] wdata;
                     int waits; bit err; logic [DW-1:0] rdata; bit b2b; } cmd_t;
    typedef struct { int cyc; logic err; logic [DW-1:0] rdata; } exp_t;

    exp_t sb[$];
    cmd_t cmds[$];
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every slave returns random PREADY/PSLVERR/PRDATA unless it is overridden afterwards.
    task automatic drive_rand();
        for (int k = 0; k < NS; k++) prdata_i[k*DW +: DW] = $urandom;
        pready_i  = NS'($urandom);
        pslverr_i = NS'($urandom);
    endtask

    task automatic set_cmd(input cmd_t c);
        cmd_addr_i = c.addr; cmd_write_i = c.wr; cmd_wdata_i = c.wdata; cmd_valid_i = 1'b1;
    endtask

    // Run one command. On entry we are #1 after an edge, the DUT is in IDLE and c is
    // already presented. On exit we are #1 into the response cycle.
    task automatic run_cmd(input cmd_t c, input bit has_nx, input cmd_t nx);
        int s, acc;
        s = int'(c.addr[AW-1 -: 2]);
        drive_rand();
        @(negedge pclk);
        chk("idle_ready", cmd_ready_o, 1);
        chk("idle_psel", psel_o, 0);
        @(posedge pclk); #1;
        acc = cyc;
        sb.push_back('{acc + 2 + c.waits, c.err, c.wr ? '0 : c.rdata});
        if (has_nx) set_cmd(nx);        // held valid must be ignored until IDLE
        else cmd_valid_i = 1'b0;
        drive_rand();
        @(negedge pclk);
        chk("setup_psel", psel_o, NS'(1) << s);
        chk("setup_penable", penable_o, 0);
        chk("setup_ready", cmd_ready_o, 0);
        chk("setup_paddr", paddr_o, c.addr);
        chk("setup_pwrite", pwrite_o, c.wr);
        chk("setup_pwdata", pwdata_o, c.wdata);
        for (int w = 0; w <= c.waits; w++) begin
            @(posedge pclk); #1;
            drive_rand();
            pready_i[s]            = (w == c.waits);
            pslverr_i[s]           = c.err;
            prdata_i[s*DW +: DW]   = c.rdata;
            @(negedge pclk);
            chk("acc_psel", psel_o, NS'(1) << s);
            chk("acc_penable", penable_o, 1);
            chk("acc_paddr", paddr_o, c.addr);
            chk("acc_pwrite", pwrite_o, c.wr);
            chk("acc_pwdata", pwdata_o, c.wdata);
        end
        @(posedge pclk); #1;
    endtask

    task automatic run_list();
        cmd_t nx;
        for (int i = 0; i < cmds.size(); i++) begin
            bit has_nx;
            if (!cmd_valid_i) begin
                repeat ($urandom_range(0, 2)) begin drive_rand(); @(posedge pclk); #1; end
                set_cmd(cmds[i]);
            end
            has_nx = cmds[i].b2b && (i + 1 < cmds.size());
            nx = has_nx ? cmds[i+1] : cmds[i];
            run_cmd(cmds[i], has_nx, nx);
        end
        cmd_valid_i = 1'b0;
        cmds.delete();
    endtask

    function automatic cmd_t mk(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                                input int w, input bit e, input logic [DW-1:0] rd, input bit b);
        cmd_t c;
        c.addr = a; c.wr = wr; c.wdata = wd; c.waits = w; c.err = e; c.rdata = rd; c.b2b = b;
        return c;
    endfunction

    // Monitor: score every response, and check that response data holds between responses.
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    always @(negedge pclk) begin
        if (preset) begin
            last_rdata = '0; last_err = 1'b0;
        end else if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got rsp_valid_o=1 want no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_err", rsp_err_o, e.err);
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
            end
            last_rdata = rsp_rdata_o; last_err = rsp_err_o;
        end else begin
            chk("rsp_hold_rdata", rsp_rdata_o, last_rdata);
            chk("rsp_hold_err", rsp_err_o, last_err);
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, cmd_ready_o, 0);
        chk({nm, "_psel"}, psel_o, 0);
        chk({nm, "_penable"}, penable_o, 0);
        chk({nm, "_paddr"}, paddr_o, 0);
        chk({nm, "_pwrite"}, pwrite_o, 0);
        chk({nm, "_pwdata"}, pwdata_o, 0);
        chk({nm, "_rspv"}, rsp_valid_o, 0);
        chk({nm, "_rdata"}, rsp_rdata_o, 0);
        chk({nm, "_err"}, rsp_err_o, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    initial begin
        int acc;
        // Outputs while reset is held.
        #2;
        chk_all_zero("reset");
        @(posedge pclk); #1;
        preset = 1'b0;

        // Directed cases: a zero-wait write, a read with waits, and a slave error.
        cmds.push_back(mk(8'h40, 1, 32'h1234ABCD, 0, 0, 32'hDEADBEEF, 0));
        cmds.push_back(mk(8'hC4, 0, 32'h0, 2, 0, 32'h5678EF01, 0));
        cmds.push_back(mk(8'h00, 0, 32'h0, 1, 1, 32'hA5A5A5A5, 0));
        run_list();

        // Reset during the ACCESS phase of a write to 0x80: the transfer must be dropped.
        drive_rand();
        set_cmd(mk(8'h80, 1, 32'hCAFEF00D, 0, 0, 0, 0));
        @(posedge pclk); #1;
        cmd_valid_i = 1'b0;
        @(posedge pclk); #1;
        drive_rand(); pready_i[2] = 1'b0;
        #2 preset = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("midrst_ready_held", cmd_ready_o, 0);
        @(posedge pclk); #1;
        preset = 1'b0;
        cmds.push_back(mk(8'h84, 1, 32'h0BADF00D, 0, 0, 0, 0));
        run_list();

        // Back-to-back writes with cmd_valid_i held high throughout.
        cmds.push_back(mk(8'h10, 1, 32'h11111111, 1, 0, 0, 1));
        cmds.push_back(mk(8'hB0, 1, 32'h22222222, 0, 0, 0, 0));
        run_list();

        // Random traffic.
        for (int i = 0; i < 40; i++)
            cmds.push_back(mk(AW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 4),
                              ($urandom_range(0, 4) == 0), $urandom, 1'($urandom)));
        run_list();

        // Slave 2 never becomes ready.
        drive_rand();
        set_cmd(mk(8'h88, 1, 32'h77777777, 0, 0, 0, 0));
        @(posedge pclk); #1;
        acc = cyc;
        cmd_valid_i = 1'b0;
`ifdef APB_TIMEOUT_EN
        sb.push_back('{acc + 1 + TMO, 1'b1, '0});
        for (int w = 0; w < TMO; w++) begin
            @(posedge pclk); #1;
            drive_rand(); pready_i[2] = 1'b0;
            @(negedge pclk);
            chk("tmo_psel", psel_o, 4'b0100);
        end
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("tmo_psel_drop", psel_o, 0);
        chk("tmo_ready", cmd_ready_o, 1);
`else
        for (int w = 0; w < 100; w++) begin
            @(posedge pclk); #1;
            drive_rand(); pready_i[2] = 1'b0;
            @(negedge pclk);
            chk("stuck_psel", psel_o, 4'b0100);
            chk("stuck_penable", penable_o, 1);
        end
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
`endif
        cmds.push_back(mk(8'h3C, 0, 32'h0, 0, 0, 32'h13579BDF, 0));
        run_list();

        repeat (3) @(posedge pclk);
        #1;
        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
